// File: rtl/wb_port_arbiter_if.sv
// Interface bundling the writeback-arbiter signals: pipeline writeback request,
// multi-cycle unit handshake, register-file write port and status outputs.
// The master side drives requests and observes the port; the slave side is the arbiter.
interface wb_port_arbiter_if #(
   parameter int FIFO_DEPTH = 2
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             pipe_we;
   logic [4:0]       pipe_reg;
   logic [31:0]      pipe_data;
   logic             mc_valid;
   logic             mc_ready;
   logic [4:0]       mc_reg;
   logic [31:0]      mc_data;
   logic             reg_write;
   logic [4:0]       write_reg;
   logic [31:0]      write_data;
   logic             stall_req;
   logic [CNT_W-1:0] pending_cnt;

   modport master (
      output pipe_we, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
      input  mc_ready, reg_write, write_reg, write_data, stall_req, pending_cnt
   );

   modport slave (
      input  pipe_we, pipe_reg, pipe_data, mc_valid, mc_reg, mc_data,
      output mc_ready, reg_write, write_reg, write_data, stall_req, pending_cnt
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter. Pipeline writeback always owns the port;
// multi-cycle unit results wait in a small FIFO and drain in idle cycles.
// A younger pipeline write to the same register kills queued entries, and a
// starvation counter requests a pipeline bubble when the FIFO head waits too long.
// Optional feature: define WB_BYPASS_EN to let a unit result use an idle port
// directly (zero latency) when the FIFO is empty, instead of being queued.
// The interface instance must be built with the same FIFO_DEPTH as this module.
module wb_port_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              resetn,
   wb_port_arbiter_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   logic [4:0]            fifo_reg  [FIFO_DEPTH];
   logic [31:0]           fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_live;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [SC_W-1:0]       starve;

   logic        empty;
   logic        full;
   logic        head_live;
   logic        pop;
   logic        push;
   logic        bypass_take;
   logic        sel_valid;
   logic [4:0]  sel_reg;
   logic [31:0] sel_data;
   logic        wr_en;

   // Port selection, FIFO handshake decode and stall request from current state and inputs
   always_comb begin
      empty       = (count == '0);
      full        = (count == CNT_W'(FIFO_DEPTH));
      head_live   = !empty && fifo_live[rd_ptr];
      pop         = resetn && !bus.pipe_we && !empty;
      bypass_take = 1'b0;
`ifdef WB_BYPASS_EN
      bypass_take = resetn && !bus.pipe_we && empty && bus.mc_valid;
`else
      bypass_take = 1'b0;
`endif
      bus.mc_ready = resetn && !full;
      push         = bus.mc_valid && bus.mc_ready && !bypass_take;

      sel_valid = 1'b0;
      sel_reg   = '0;
      sel_data  = '0;
      if (bus.pipe_we) begin
         sel_valid = 1'b1;
         sel_reg   = bus.pipe_reg;
         sel_data  = bus.pipe_data;
      end else if (!empty) begin
         sel_valid = fifo_live[rd_ptr];
         sel_reg   = fifo_reg[rd_ptr];
         sel_data  = fifo_data[rd_ptr];
      end else if (bypass_take) begin
         sel_valid = 1'b1;
         sel_reg   = bus.mc_reg;
         sel_data  = bus.mc_data;
      end

      wr_en           = resetn && sel_valid && (sel_reg != 5'd0);
      bus.reg_write   = wr_en;
      bus.write_reg   = wr_en ? sel_reg : 5'd0;
      bus.write_data  = wr_en ? sel_data : 32'd0;
      bus.stall_req   = resetn && head_live && (starve == SC_W'(STARVE_LIMIT));
      bus.pending_cnt = count;
   end

   // Payload storage; contents are only meaningful while the matching slot is occupied
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]  <= bus.mc_reg;
         fifo_data[wr_ptr] <= bus.mc_data;
      end
   end

   // Pointers, occupancy, live bits (WAW kill) and the starvation counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         fifo_live <= '0;
         starve    <= '0;
      end else begin
         if (bus.pipe_we && (bus.pipe_reg != 5'd0)) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               if (fifo_reg[i] == bus.pipe_reg) begin
                  fifo_live[i] <= 1'b0;
               end
            end
         end
         if (push) begin
            fifo_live[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);

         if (empty || pop) begin
            starve <= '0;
         end else if (head_live && bus.pipe_we && (starve != SC_W'(STARVE_LIMIT))) begin
            starve <= starve + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
// Inputs change after the falling edge; outputs are compared 1 ns later, well
// before the next rising edge, so each record describes one clock cycle.
module tb_wb_port_arbiter;
   logic clk;
   logic resetn;

   int checks;
   int fails;

   wb_port_arbiter_if #(.FIFO_DEPTH(2)) bus ();

   wb_port_arbiter #(
      .FIFO_DEPTH  (2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic        rn;
      logic        pwe;
      logic [4:0]  preg;
      logic [31:0] pdata;
      logic        mv;
      logic [4:0]  mreg;
      logic [31:0] mdata;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        rdy;
      logic        stall;
      logic [1:0]  pcnt;
   } vec_t;

   vec_t vecs[23];

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      resetn        = v.rn;
      bus.pipe_we   = v.pwe;
      bus.pipe_reg  = v.preg;
      bus.pipe_data = v.pdata;
      bus.mc_valid  = v.mv;
      bus.mc_reg    = v.mreg;
      bus.mc_data   = v.mdata;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic checkAll(input vec_t v);
      checkOutput({v.name, ".reg_write"},   32'(bus.reg_write),   32'(v.rw));
      checkOutput({v.name, ".write_reg"},   32'(bus.write_reg),   32'(v.wreg));
      checkOutput({v.name, ".write_data"},  bus.write_data,       v.wdata);
      checkOutput({v.name, ".mc_ready"},    32'(bus.mc_ready),    32'(v.rdy));
      checkOutput({v.name, ".stall_req"},   32'(bus.stall_req),   32'(v.stall));
      checkOutput({v.name, ".pending_cnt"}, 32'(bus.pending_cnt), 32'(v.pcnt));
   endtask

   function automatic vec_t mk(input string name, input logic rn, input logic pwe,
                               input logic [4:0] preg, input logic [31:0] pdata,
                               input logic mv, input logic [4:0] mreg, input logic [31:0] mdata,
                               input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
                               input logic rdy, input logic stall, input logic [1:0] pcnt);
      vec_t v;
      v.name = name; v.rn = rn; v.pwe = pwe; v.preg = preg; v.pdata = pdata;
      v.mv = mv; v.mreg = mreg; v.mdata = mdata; v.rw = rw; v.wreg = wreg;
      v.wdata = wdata; v.rdy = rdy; v.stall = stall; v.pcnt = pcnt;
      return v;
   endfunction

   // Main sequence: reset, vector table, then multi-cycle corner cases
   initial begin
      vec_t v;
      checks = 0;
      fails  = 0;

      vecs[0]  = mk("rst2",    0,0,0,0,        1,9,'h99,     0,0,0,        0,0,0);
`ifdef WB_BYPASS_EN
      vecs[1]  = mk("push5",   1,0,0,0,        1,5,'h1234,   1,5,'h1234,   1,0,0);
      vecs[2]  = mk("drain5",  1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
`else
      vecs[1]  = mk("push5",   1,0,0,0,        1,5,'h1234,   0,0,0,        1,0,0);
      vecs[2]  = mk("drain5",  1,0,0,0,        0,0,0,        1,5,'h1234,   1,0,1);
`endif
      vecs[3]  = mk("idle0",   1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
      vecs[4]  = mk("full_a",  1,1,1,'h11,     1,10,'hA0,    1,1,'h11,     1,0,0);
      vecs[5]  = mk("full_b",  1,1,2,'h22,     1,11,'hA1,    1,2,'h22,     1,0,1);
      vecs[6]  = mk("full_c",  1,1,1,'h33,     1,12,'hA2,    1,1,'h33,     0,0,2);
      vecs[7]  = mk("full_d",  1,1,2,'h44,     1,12,'hA2,    1,2,'h44,     0,0,2);
      vecs[8]  = mk("drain_a", 1,0,0,0,        1,12,'hA2,    1,10,'hA0,    0,0,2);
      vecs[9]  = mk("drain_b", 1,0,0,0,        1,12,'hA2,    1,11,'hA1,    1,0,1);
      vecs[10] = mk("drain_c", 1,0,0,0,        0,0,0,        1,12,'hA2,    1,0,1);
      vecs[11] = mk("idle1",   1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
      vecs[12] = mk("waw_q",   1,1,1,'h01,     1,7,'hAA,     1,1,'h01,     1,0,0);
      vecs[13] = mk("waw_p",   1,1,7,'hBB,     0,0,0,        1,7,'hBB,     1,0,1);
      vecs[14] = mk("waw_pop", 1,0,0,0,        0,0,0,        0,0,0,        1,0,1);
      vecs[15] = mk("idle2",   1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
      vecs[16] = mk("same_q",  1,1,8,'hC0,     1,8,'hC1,     1,8,'hC0,     1,0,0);
      vecs[17] = mk("same_d",  1,0,0,0,        0,0,0,        1,8,'hC1,     1,0,1);
      vecs[18] = mk("idle3",   1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
      vecs[19] = mk("r0_q",    1,1,4,'h44,     1,0,'hFF,     1,4,'h44,     1,0,0);
      vecs[20] = mk("r0_pop",  1,0,0,0,        0,0,0,        0,0,0,        1,0,1);
      vecs[21] = mk("idle4",   1,0,0,0,        0,0,0,        0,0,0,        1,0,0);
      vecs[22] = mk("pipe_r0", 1,1,0,'h55,     0,0,0,        0,0,0,        1,0,0);

      $display("[TB] start");

      // First reset cycle: state is still unknown, only the reset-gated outputs are defined
      v = mk("rst1", 0,0,0,0, 1,9,'h99, 0,0,0, 0,0,0);
      applyStimulus(v);
      checkOutput("rst1.reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("rst1.mc_ready",  32'(bus.mc_ready),  32'd0);

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i]);
         checkAll(vecs[i]);
      end

      // Starvation: queue r3 while the pipe keeps the port busy
      v = mk("stv_q", 1,1,1,'h5, 1,3,1, 1,1,'h5, 1,0,0);
      applyStimulus(v); checkAll(v);
      for (int k = 1; k <= 4; k++) begin
         v = mk($sformatf("stv_w%0d", k), 1,1,2,32'h10 + k, 0,0,0, 1,2,32'h10 + k, 1,0,1);
         applyStimulus(v); checkAll(v);
      end
      v = mk("stv_hi", 1,1,2,'h65, 0,0,0, 1,2,'h65, 1,1,1);
      applyStimulus(v); checkAll(v);
      v = mk("stv_sat", 1,1,2,'h66, 0,0,0, 1,2,'h66, 1,1,1);
      applyStimulus(v); checkAll(v);
      v = mk("stv_drain", 1,0,0,0, 0,0,0, 1,3,1, 1,1,1);
      applyStimulus(v); checkAll(v);
      v = mk("stv_low", 1,0,0,0, 0,0,0, 0,0,0, 1,0,0);
      applyStimulus(v); checkAll(v);

      // Reset while an entry is pending discards it
      v = mk("rmid_q", 1,1,1,'h7, 1,6,'h66, 1,1,'h7, 1,0,0);
      applyStimulus(v); checkAll(v);
      v = mk("rmid_rst", 0,0,0,0, 0,0,0, 0,0,0, 0,0,1);
      applyStimulus(v); checkAll(v);
      v = mk("rmid_after", 1,0,0,0, 0,0,0, 0,0,0, 1,0,0);
      applyStimulus(v); checkAll(v);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
